// File: rtl/vx_io_bus_arb_pkg.sv
// Shared definitions for the I/O bus arbiter slice.
// Contents: I/O request field widths, output-stage state encoding, and the
// requester-index width helper used by the interface, arbiter and top.
package vx_io_bus_arb_pkg;

    localparam int IO_ADDR_WIDTH   = 30;
    localparam int IO_BYTEEN_WIDTH = 4;
    localparam int IO_DATA_WIDTH   = 32;

    typedef enum logic {
        STAGE_EMPTY = 1'b0,
        STAGE_FULL  = 1'b1
    } stage_state_e;

    // Index width for n requesters; never below one bit.
    function automatic int lg_reqs(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_io_bus_arb_if.sv
// Bus bundle between NUM_REQS requesters, the arbiter and the core I/O bus.
//   in_req_*  : requester-side requests (per requester, per lane)
//   out_req_* : core-side request bus, tag = {requester tag, requester index}
//   out_rsp_* : core-side single-lane response bus
//   in_rsp_*  : responses routed back to the requesters
// Modports: slave = the arbiter's view, master = the environment's view.
interface vx_io_bus_arb_if #(
    parameter int NUM_REQS      = 4,
    parameter int NUM_LANES     = 4,
    parameter int REQ_TAG_WIDTH = 8
);
    import vx_io_bus_arb_pkg::*;

    localparam int LG_REQS       = lg_reqs(NUM_REQS);
    localparam int OUT_TAG_WIDTH = REQ_TAG_WIDTH + LG_REQS;

    logic [NUM_REQS-1:0][NUM_LANES-1:0]                      in_req_valid;
    logic [NUM_REQS-1:0]                                     in_req_rw;
    logic [NUM_REQS-1:0][NUM_LANES-1:0][IO_BYTEEN_WIDTH-1:0] in_req_byteen;
    logic [NUM_REQS-1:0][NUM_LANES-1:0][IO_ADDR_WIDTH-1:0]   in_req_addr;
    logic [NUM_REQS-1:0][NUM_LANES-1:0][IO_DATA_WIDTH-1:0]   in_req_data;
    logic [NUM_REQS-1:0][REQ_TAG_WIDTH-1:0]                  in_req_tag;
    logic [NUM_REQS-1:0]                                     in_req_ready;

    logic [NUM_LANES-1:0]                      out_req_valid;
    logic                                      out_req_rw;
    logic [NUM_LANES-1:0][IO_BYTEEN_WIDTH-1:0] out_req_byteen;
    logic [NUM_LANES-1:0][IO_ADDR_WIDTH-1:0]   out_req_addr;
    logic [NUM_LANES-1:0][IO_DATA_WIDTH-1:0]   out_req_data;
    logic [OUT_TAG_WIDTH-1:0]                  out_req_tag;
    logic                                      out_req_ready;

    logic                     out_rsp_valid;
    logic [IO_DATA_WIDTH-1:0] out_rsp_data;
    logic [OUT_TAG_WIDTH-1:0] out_rsp_tag;
    logic                     out_rsp_ready;

    logic [NUM_REQS-1:0]      in_rsp_valid;
    logic [IO_DATA_WIDTH-1:0] in_rsp_data;
    logic [REQ_TAG_WIDTH-1:0] in_rsp_tag;
    logic [NUM_REQS-1:0]      in_rsp_ready;

    modport slave (
        input  in_req_valid, in_req_rw, in_req_byteen, in_req_addr, in_req_data, in_req_tag,
        output in_req_ready,
        output out_req_valid, out_req_rw, out_req_byteen, out_req_addr, out_req_data, out_req_tag,
        input  out_req_ready,
        input  out_rsp_valid, out_rsp_data, out_rsp_tag,
        output out_rsp_ready,
        output in_rsp_valid, in_rsp_data, in_rsp_tag,
        input  in_rsp_ready
    );

    modport master (
        output in_req_valid, in_req_rw, in_req_byteen, in_req_addr, in_req_data, in_req_tag,
        input  in_req_ready,
        input  out_req_valid, out_req_rw, out_req_byteen, out_req_addr, out_req_data, out_req_tag,
        output out_req_ready,
        output out_rsp_valid, out_rsp_data, out_rsp_tag,
        input  out_rsp_ready,
        input  in_rsp_valid, in_rsp_data, in_rsp_tag,
        output in_rsp_ready
    );

endinterface

// File: rtl/vx_io_bus_arb_rr_arbiter.sv
// Round-robin arbiter (module vx_rr_arbiter).
//   clk, reset   : clock, asynchronous active-high reset
//   requests     : one bit per requester
//   update       : winner was accepted; it becomes lowest priority next
//   grant_onehot : one-hot winner (zero when nothing requests)
//   grant_index  : binary winner index
//   grant_valid  : at least one requester is active
// After reset last_grant is NUM_REQS-1, so requester 0 wins first.
module vx_rr_arbiter
    import vx_io_bus_arb_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int LG_REQS  = lg_reqs(NUM_REQS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] requests,
    input  logic                update,
    output logic [NUM_REQS-1:0] grant_onehot,
    output logic [LG_REQS-1:0]  grant_index,
    output logic                grant_valid
);
    // One extra bit so last_grant + k (up to 2*NUM_REQS-1) cannot overflow.
    localparam int CW = LG_REQS + 1;

    logic [LG_REQS-1:0] last_grant_reg;
    logic [CW-1:0]      cand;
    logic               found;

    assign grant_valid = |requests;

    // Scan from last_grant+1 upward with wrap; first active requester wins.
    always_comb begin
        grant_index = '0;
        found       = 1'b0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQS; k++) begin
            cand = {1'b0, last_grant_reg} + CW'(k);
            if (cand >= CW'(NUM_REQS)) begin
                cand = cand - CW'(NUM_REQS);
            end
            if (!found && requests[cand[LG_REQS-1:0]]) begin
                found       = 1'b1;
                grant_index = cand[LG_REQS-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_onehot
            assign grant_onehot[gi] = grant_valid && (grant_index == LG_REQS'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_reg <= LG_REQS'(NUM_REQS - 1);
        end else if (update && grant_valid) begin
            last_grant_reg <= grant_index;
        end
    end

endmodule

// File: rtl/vx_io_bus_arb.sv
// Shares one core-side I/O bus between NUM_REQS requesters.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : request/response bundle (slave view)
//   busy       : output stage holds a request or reads are outstanding
// The granted request is registered in a single output stage with the
// requester index appended to its tag; responses are routed back by that
// index. Outstanding reads are capped at MAX_PENDING; writes are never held.
module vx_io_bus_arb
    import vx_io_bus_arb_pkg::*;
#(
    parameter int NUM_REQS      = 4,
    parameter int NUM_LANES     = 4,
    parameter int REQ_TAG_WIDTH = 8,
    parameter int MAX_PENDING   = 8
) (
    input  logic             clk,
    input  logic             reset,
    vx_io_bus_arb_if.slave   bus,
    output logic             busy
);
    localparam int LG_REQS       = lg_reqs(NUM_REQS);
    localparam int OUT_TAG_WIDTH = REQ_TAG_WIDTH + LG_REQS;
    localparam int PEND_WIDTH    = $clog2(MAX_PENDING) + 1;

    logic [NUM_REQS-1:0] req_active;
    logic [NUM_REQS-1:0] win_onehot;
    logic [LG_REQS-1:0]  win_idx;
    logic                win_valid;
    logic                win_rw;

    stage_state_e state_reg, state_next;
    logic         stage_free, can_grant, accept, throttled;
    logic         out_fire, out_read_fire, rsp_fire;

    logic [NUM_LANES-1:0]                      valid_reg;
    logic                                      rw_reg;
    logic [NUM_LANES-1:0][IO_BYTEEN_WIDTH-1:0] byteen_reg;
    logic [NUM_LANES-1:0][IO_ADDR_WIDTH-1:0]   addr_reg;
    logic [NUM_LANES-1:0][IO_DATA_WIDTH-1:0]   data_reg;
    logic [OUT_TAG_WIDTH-1:0]                  tag_reg;

    logic [PEND_WIDTH-1:0] pending_reg, pending_next;

    logic [LG_REQS-1:0]  rsp_idx;
    logic                rsp_idx_ok;
    logic [NUM_REQS-1:0] rsp_onehot;

    // ---------------- arbitration ----------------
    generate
        for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_active
            assign req_active[gi] = |bus.in_req_valid[gi];
        end
    endgenerate

    vx_rr_arbiter #(
        .NUM_REQS (NUM_REQS),
        .LG_REQS  (LG_REQS)
    ) u_arb (
        .clk          (clk),
        .reset        (reset),
        .requests     (req_active),
        .update       (accept),
        .grant_onehot (win_onehot),
        .grant_index  (win_idx),
        .grant_valid  (win_valid)
    );

    assign win_rw = bus.in_req_rw[win_idx];

    // ---------------- handshakes ----------------
    assign out_fire      = (state_reg == STAGE_FULL) && bus.out_req_ready;
    assign out_read_fire = out_fire && !rw_reg;
    assign rsp_fire      = bus.out_rsp_valid && bus.out_rsp_ready;
    assign stage_free    = (state_reg == STAGE_EMPTY) || bus.out_req_ready;

    // pending_next already includes a read leaving the stage and a response
    // retiring this cycle, so a blocked read is released in the same cycle a
    // response is accepted and the bound can never be exceeded.
    always_comb begin
        pending_next = pending_reg;
        if (out_read_fire && !rsp_fire) begin
            pending_next = pending_reg + 1'b1;
        end else if (!out_read_fire && rsp_fire && (pending_reg != '0)) begin
            pending_next = pending_reg - 1'b1;
        end
    end

    assign throttled = (pending_next == PEND_WIDTH'(MAX_PENDING)) && !win_rw;
    assign can_grant = stage_free && !throttled;

    // ---------------- output-stage FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= STAGE_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        accept           = 1'b0;
        bus.in_req_ready = '0;
        if (can_grant) begin
            bus.in_req_ready = win_onehot;
            accept           = win_valid;
        end
        if (accept) begin
            state_next = STAGE_FULL;
        end else if (stage_free) begin
            state_next = STAGE_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg  <= '0;
            rw_reg     <= 1'b0;
            byteen_reg <= '0;
            addr_reg   <= '0;
            data_reg   <= '0;
            tag_reg    <= '0;
        end else if (accept) begin
            valid_reg  <= bus.in_req_valid[win_idx];
            rw_reg     <= win_rw;
            byteen_reg <= bus.in_req_byteen[win_idx];
            addr_reg   <= bus.in_req_addr[win_idx];
            data_reg   <= bus.in_req_data[win_idx];
            tag_reg    <= {bus.in_req_tag[win_idx], win_idx};
        end else if (stage_free) begin
            valid_reg  <= '0;
        end
    end

    assign bus.out_req_valid  = valid_reg;
    assign bus.out_req_rw     = rw_reg;
    assign bus.out_req_byteen = byteen_reg;
    assign bus.out_req_addr   = addr_reg;
    assign bus.out_req_data   = data_reg;
    assign bus.out_req_tag    = tag_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign busy = (state_reg == STAGE_FULL) || (pending_reg != '0);

    // ---------------- response routing ----------------
    assign rsp_idx = bus.out_rsp_tag[LG_REQS-1:0];

    generate
        if ((2 ** LG_REQS) > NUM_REQS) begin : g_idx_chk
            assign rsp_idx_ok = (rsp_idx < LG_REQS'(NUM_REQS));
        end else begin : g_idx_full
            assign rsp_idx_ok = 1'b1;
        end
        for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_rsp
            assign rsp_onehot[gi] = (rsp_idx == LG_REQS'(gi));
        end
    endgenerate

    // An out-of-range index is swallowed so the bus cannot lock up.
    assign bus.out_rsp_ready = rsp_idx_ok ? (|(bus.in_rsp_ready & rsp_onehot)) : 1'b1;
    assign bus.in_rsp_valid  = (bus.out_rsp_valid && rsp_idx_ok) ? rsp_onehot : '0;
    assign bus.in_rsp_data   = bus.out_rsp_data;
    assign bus.in_rsp_tag    = bus.out_rsp_tag[OUT_TAG_WIDTH-1:LG_REQS];

    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(rsp_fire && (pending_reg == '0)));
    a_rsp_idx_range: assert property (@(posedge clk) disable iff (reset)
        !(bus.out_rsp_valid && !rsp_idx_ok));

endmodule

// File: tb/tb_vx_io_bus_arb.sv
// Directed self-checking bench for vx_io_bus_arb.
module tb_vx_io_bus_arb;
    import vx_io_bus_arb_pkg::*;

    localparam int NUM_REQS      = 4;
    localparam int NUM_LANES     = 4;
    localparam int REQ_TAG_WIDTH = 8;
    localparam int MAX_PENDING   = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    int   tests = 0;
    int   fails = 0;

    vx_io_bus_arb_if #(
        .NUM_REQS(NUM_REQS), .NUM_LANES(NUM_LANES), .REQ_TAG_WIDTH(REQ_TAG_WIDTH)
    ) bus ();

    vx_io_bus_arb #(
        .NUM_REQS(NUM_REQS), .NUM_LANES(NUM_LANES),
        .REQ_TAG_WIDTH(REQ_TAG_WIDTH), .MAX_PENDING(MAX_PENDING)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        bus.in_req_valid  = '0;
        bus.in_req_rw     = '0;
        bus.in_req_byteen = '0;
        bus.in_req_addr   = '0;
        bus.in_req_data   = '0;
        bus.in_req_tag    = '0;
        bus.out_req_ready = 1'b0;
        bus.out_rsp_valid = 1'b0;
        bus.out_rsp_data  = '0;
        bus.out_rsp_tag   = '0;
        bus.in_rsp_ready  = '0;
    endtask

    task automatic drive_req(input logic [1:0] r, input logic rw, input logic [3:0] mask,
                             input logic [29:0] addr, input logic [7:0] tag);
        bus.in_req_valid[r] = mask;
        bus.in_req_rw[r]    = rw;
        bus.in_req_tag[r]   = tag;
        for (int l = 0; l < NUM_LANES; l++) begin
            bus.in_req_byteen[r][l[1:0]] = 4'hF;
            bus.in_req_addr[r][l[1:0]]   = addr + 30'(l);
            bus.in_req_data[r][l[1:0]]   = 32'hA000_0000 | 32'({r, l[1:0]});
        end
    endtask

    task automatic drop_req(input logic [1:0] r);
        bus.in_req_valid[r] = '0;
    endtask

    // Ends just after a falling edge with reset released.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Issues n reads from requester r and drains the stage; pending becomes n.
    task automatic fill_reads(input logic [1:0] r, input int n);
        bus.out_req_ready = 1'b1;
        drive_req(r, 1'b0, 4'hF, 30'h1000, 8'h00);
        for (int k = 0; k < n; k++) begin
            bus.in_req_tag[r] = 8'(k);
            @(posedge clk);
            @(negedge clk);
        end
        drop_req(r);
        @(posedge clk);
        @(negedge clk);
        bus.out_req_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        tests++; if (bus.out_req_valid !== 4'b0000) begin fails++; $display("FAIL reset_valid got=%b exp=0000", bus.out_req_valid); end
        tests++; if (bus.in_req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got=%b exp=0000", bus.in_req_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (bus.out_req_tag !== 10'h000) begin fails++; $display("FAIL reset_tag got=%h exp=000", bus.out_req_tag); end
        drive_req(2'd2, 1'b1, 4'b1011, 30'h3FFF_FF00, 8'h15);
        #1;
        tests++; if (bus.in_req_ready !== 4'b0100) begin fails++; $display("FAIL first_grant got=%b exp=0100", bus.in_req_ready); end
        @(posedge clk); #1;
        $display("[TB] txn req2 write tag=%h", bus.out_req_tag);
        tests++; if (bus.out_req_valid !== 4'b1011) begin fails++; $display("FAIL first_valid got=%b exp=1011", bus.out_req_valid); end
        tests++; if (bus.out_req_tag !== 10'h056) begin fails++; $display("FAIL first_tag got=%h exp=056", bus.out_req_tag); end
        tests++; if (bus.out_req_addr[0] !== 30'h3FFF_FF00) begin fails++; $display("FAIL first_addr got=%h exp=3fffff00", bus.out_req_addr[0]); end
        tests++; if (bus.out_req_rw !== 1'b1) begin fails++; $display("FAIL first_rw got=%b exp=1", bus.out_req_rw); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL first_busy got=%b exp=1", busy); end
        @(negedge clk);
        drop_req(2'd2);
        bus.out_req_ready = 1'b1;
        @(posedge clk); #1;
        tests++; if (bus.out_req_valid !== 4'b0000) begin fails++; $display("FAIL drain_valid got=%b exp=0000", bus.out_req_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL drain_busy got=%b exp=0", busy); end
        @(negedge clk);
        bus.out_req_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        logic [9:0] exp_tag;
        do_reset();
        for (int i = 0; i < NUM_REQS; i++) begin
            drive_req(i[1:0], 1'b1, 4'hF, 30'(i) << 8, 8'h40 + 8'(i));
        end
        bus.out_req_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            exp_rdy = 4'b0001 << (c % 4);
            exp_tag = {8'h40 + 8'(c % 4), 2'(c % 4)};
            #1;
            tests++; if (bus.in_req_ready !== exp_rdy) begin fails++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, bus.in_req_ready, exp_rdy); end
            @(posedge clk); #1;
            $display("[TB] txn rr cycle %0d tag=%h", c, bus.out_req_tag);
            tests++; if (bus.out_req_tag !== exp_tag) begin fails++; $display("FAIL rr_tag c=%0d got=%h exp=%h", c, bus.out_req_tag, exp_tag); end
            tests++; if (bus.out_req_valid !== 4'hF) begin fails++; $display("FAIL rr_valid c=%0d got=%b exp=1111", c, bus.out_req_valid); end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        drive_req(2'd1, 1'b1, 4'hF, 30'h100, 8'h21);
        #1;
        tests++; if (bus.in_req_ready !== 4'b0010) begin fails++; $display("FAIL stall_load_ready got=%b exp=0010", bus.in_req_ready); end
        @(posedge clk);
        @(negedge clk);
        drop_req(2'd1);
        drive_req(2'd2, 1'b1, 4'hF, 30'h200, 8'h22);
        for (int c = 0; c < 5; c++) begin
            #1;
            tests++; if (bus.in_req_ready !== 4'b0000) begin fails++; $display("FAIL stall_ready c=%0d got=%b exp=0000", c, bus.in_req_ready); end
            @(posedge clk); #1;
            tests++; if (bus.out_req_tag !== 10'h085) begin fails++; $display("FAIL stall_tag c=%0d got=%h exp=085", c, bus.out_req_tag); end
            tests++; if (bus.out_req_addr[0] !== 30'h100) begin fails++; $display("FAIL stall_addr c=%0d got=%h exp=100", c, bus.out_req_addr[0]); end
            tests++; if (bus.out_req_valid !== 4'hF) begin fails++; $display("FAIL stall_valid c=%0d got=%b exp=1111", c, bus.out_req_valid); end
            @(negedge clk);
        end
        bus.out_req_ready = 1'b1;
        #1;
        tests++; if (bus.in_req_ready !== 4'b0100) begin fails++; $display("FAIL release_ready got=%b exp=0100", bus.in_req_ready); end
        @(posedge clk); #1;
        $display("[TB] txn stall release tag=%h", bus.out_req_tag);
        tests++; if (bus.out_req_tag !== 10'h08A) begin fails++; $display("FAIL release_tag got=%h exp=08a", bus.out_req_tag); end
        tests++; if (bus.out_req_addr[0] !== 30'h200) begin fails++; $display("FAIL release_addr got=%h exp=200", bus.out_req_addr[0]); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_throttle();
        do_reset();
        fill_reads(2'd1, 8);
        bus.out_req_ready = 1'b1;
        drive_req(2'd1, 1'b0, 4'hF, 30'h2000, 8'h91);
        #1;
        tests++; if (bus.in_req_ready !== 4'b0000) begin fails++; $display("FAIL thr_block got=%b exp=0000", bus.in_req_ready); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL thr_busy got=%b exp=1", busy); end
        @(posedge clk); #1;
        tests++; if (bus.out_req_valid !== 4'b0000) begin fails++; $display("FAIL thr_empty got=%b exp=0000", bus.out_req_valid); end
        @(negedge clk);
        drive_req(2'd3, 1'b1, 4'hF, 30'h3000, 8'h30);
        #1;
        tests++; if (bus.in_req_ready !== 4'b1000) begin fails++; $display("FAIL thr_write_ready got=%b exp=1000", bus.in_req_ready); end
        @(posedge clk); #1;
        $display("[TB] txn write during throttle tag=%h", bus.out_req_tag);
        tests++; if (bus.out_req_tag !== 10'h0C3) begin fails++; $display("FAIL thr_write_tag got=%h exp=0c3", bus.out_req_tag); end
        tests++; if (bus.out_req_rw !== 1'b1) begin fails++; $display("FAIL thr_write_rw got=%b exp=1", bus.out_req_rw); end
        @(negedge clk);
        drop_req(2'd3);
        #1;
        tests++; if (bus.in_req_ready !== 4'b0000) begin fails++; $display("FAIL thr_block2 got=%b exp=0000", bus.in_req_ready); end
        @(posedge clk);
        @(negedge clk);
        bus.out_rsp_valid = 1'b1;
        bus.out_rsp_tag   = 10'h01D;
        bus.out_rsp_data  = 32'hDEAD_BEEF;
        bus.in_rsp_ready  = 4'b0010;
        #1;
        $display("[TB] txn response tag=%h", bus.out_rsp_tag);
        tests++; if (bus.in_rsp_valid !== 4'b0010) begin fails++; $display("FAIL rsp_valid got=%b exp=0010", bus.in_rsp_valid); end
        tests++; if (bus.in_rsp_tag !== 8'h07) begin fails++; $display("FAIL rsp_tag got=%h exp=07", bus.in_rsp_tag); end
        tests++; if (bus.in_rsp_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rsp_data got=%h exp=deadbeef", bus.in_rsp_data); end
        tests++; if (bus.out_rsp_ready !== 1'b1) begin fails++; $display("FAIL rsp_ready got=%b exp=1", bus.out_rsp_ready); end
        tests++; if (bus.in_req_ready !== 4'b0010) begin fails++; $display("FAIL thr_release got=%b exp=0010", bus.in_req_ready); end
        @(posedge clk); #1;
        tests++; if (bus.out_req_tag !== 10'h245) begin fails++; $display("FAIL thr_read_tag got=%h exp=245", bus.out_req_tag); end
        tests++; if (bus.out_req_rw !== 1'b0) begin fails++; $display("FAIL thr_read_rw got=%b exp=0", bus.out_req_rw); end
        @(negedge clk);
        bus.out_rsp_valid = 1'b0;
        bus.in_rsp_ready  = '0;
        #1;
        tests++; if (bus.in_req_ready !== 4'b0000) begin fails++; $display("FAIL thr_reblock got=%b exp=0000", bus.in_req_ready); end
        clear_inputs();
    endtask

    task automatic test_rsp_backpressure();
        do_reset();
        fill_reads(2'd0, 8);
        bus.out_req_ready = 1'b1;
        drive_req(2'd2, 1'b0, 4'hF, 30'h4000, 8'h52);
        bus.out_rsp_valid = 1'b1;
        bus.out_rsp_tag   = 10'h0CF;
        bus.out_rsp_data  = 32'h1234_5678;
        bus.in_rsp_ready  = 4'b0111;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++; if (bus.out_rsp_ready !== 1'b0) begin fails++; $display("FAIL bp_ready c=%0d got=%b exp=0", c, bus.out_rsp_ready); end
            tests++; if (bus.in_rsp_valid !== 4'b1000) begin fails++; $display("FAIL bp_valid c=%0d got=%b exp=1000", c, bus.in_rsp_valid); end
            tests++; if (bus.in_rsp_tag !== 8'h33) begin fails++; $display("FAIL bp_tag c=%0d got=%h exp=33", c, bus.in_rsp_tag); end
            tests++; if (bus.in_req_ready !== 4'b0000) begin fails++; $display("FAIL bp_pending_held c=%0d got=%b exp=0000", c, bus.in_req_ready); end
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_rsp_ready = 4'b1111;
        #1;
        tests++; if (bus.out_rsp_ready !== 1'b1) begin fails++; $display("FAIL bp_release got=%b exp=1", bus.out_rsp_ready); end
        tests++; if (bus.in_req_ready !== 4'b0100) begin fails++; $display("FAIL bp_grant got=%b exp=0100", bus.in_req_ready); end
        @(posedge clk); #1;
        $display("[TB] txn read after backpressure tag=%h", bus.out_req_tag);
        tests++; if (bus.out_req_tag !== 10'h14A) begin fails++; $display("FAIL bp_tag_out got=%h exp=14a", bus.out_req_tag); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        fill_reads(2'd0, 5);
        drive_req(2'd2, 1'b1, 4'hF, 30'h5000, 8'h66);
        @(posedge clk); #1;
        tests++; if (bus.out_req_valid !== 4'hF) begin fails++; $display("FAIL mid_full got=%b exp=1111", bus.out_req_valid); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy got=%b exp=1", busy); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++; if (bus.out_req_valid !== 4'b0000) begin fails++; $display("FAIL mid_clear got=%b exp=0000", bus.out_req_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy_clear got=%b exp=0", busy); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            drive_req(i[1:0], 1'b1, 4'hF, 30'h6000, 8'h70 + 8'(i));
        end
        bus.out_req_ready = 1'b1;
        #1;
        tests++; if (bus.in_req_ready !== 4'b0001) begin fails++; $display("FAIL mid_priority got=%b exp=0001", bus.in_req_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_pending got=%b exp=0", busy); end
        @(posedge clk); #1;
        tests++; if (bus.out_req_tag !== 10'h1C0) begin fails++; $display("FAIL mid_tag got=%h exp=1c0", bus.out_req_tag); end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        do_reset();
        test_reset();
        test_round_robin();
        test_stall();
        test_throttle();
        test_rsp_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
